seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 139 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a frame-synchronous shadow register,
// anti-ghosting blank interval, leading-zero suppression and a frame-boundary load handshake.
module seg_scan_ctrl #(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_bcd,
    input  logic [3:0]  load_dp,
    input  logic        lz_suppress,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] BlankLast = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SlotLast  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] SlotPrev  = CW'(DIGIT_CYCLES - 2);

    typedef enum logic [1:0] {StOff, StBlank, StShow} state_e;

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [15:0]     shadow_bcd;
    logic [3:0]      shadow_dp;

    logic [3:0]      cur_digit;
    logic [3:0]      zero;
    logic [3:0]      lz_blank;
    logic [6:0]      dec;
    logic [7:0]      show_seg;
    logic [3:0]      show_an;

    always_comb begin
        cur_digit = shadow_bcd[{idx, 2'b00} +: 4];
        for (int i = 0; i < 4; i++) begin
            zero[i] = (shadow_bcd[4*i +: 4] == 4'd0);
        end
        // A digit is blanked only if it and every more-significant digit are zero.
        lz_blank[3] = lz_suppress & zero[3];
        lz_blank[2] = lz_blank[3] & zero[2];
        lz_blank[1] = lz_blank[2] & zero[1];
        lz_blank[0] = 1'b0;

        unique case (cur_digit)
            4'd0:    dec = 7'h40;
            4'd1:    dec = 7'h79;
            4'd2:    dec = 7'h24;
            4'd3:    dec = 7'h30;
            4'd4:    dec = 7'h19;
            4'd5:    dec = 7'h12;
            4'd6:    dec = 7'h02;
            4'd7:    dec = 7'h78;
            4'd8:    dec = 7'h00;
            4'd9:    dec = 7'h10;
            default: dec = 7'h7F;
        endcase

        show_seg = {~shadow_dp[idx], lz_blank[idx] ? 7'h7F : dec};
        show_an  = ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StOff;
            cnt        <= '0;
            idx        <= 2'd0;
            shadow_bcd <= 16'h0000;
            shadow_dp  <= 4'h0;
            an         <= 4'hF;
            seg        <= 8'hFF;
            load_ready <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            load_ready <= 1'b0;
            frame_done <= 1'b0;

            if (load_ready && load_valid) begin
                shadow_bcd <= load_bcd;
                shadow_dp  <= load_dp;
            end

            // Outputs follow the current state, so they lag state/index by one clock.
            if (state == StShow) begin
                an  <= show_an;
                seg <= show_seg;
            end else begin
                an  <= 4'hF;
                seg <= 8'hFF;
            end

            if (!enable) begin
                state <= StOff;
                cnt   <= '0;
                idx   <= 2'd0;
            end else begin
                case (state)
                    StOff: begin
                        state <= StBlank;
                        cnt   <= '0;
                        idx   <= 2'd0;
                    end
                    StBlank: begin
                        if (cnt == BlankLast) begin
                            state <= StShow;
                        end
                        cnt <= cnt + CW'(1);
                    end
                    StShow: begin
                        if (cnt == SlotLast) begin
                            state <= StBlank;
                            cnt   <= '0;
                            idx   <= idx + 2'd1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                        // Registered, so the pulse lands on the slot's final cycle.
                        if (idx == 2'd3 && cnt == SlotPrev) begin
                            frame_done <= 1'b1;
                            load_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state <= StOff;
                        cnt   <= '0;
                        idx   <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with DIGIT_CYCLES=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_bcd;
    logic [3:0]  load_dp;
    logic        lz_suppress;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Samples k=1..32 after a frame_done sample (k=0).
    logic [3:0] an_k  [0:32];
    logic [7:0] seg_k [0:32];
    logic       fd_k  [0:32];
    logic       lr_k  [0:32];

    seg_scan_ctrl #(
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_bcd    (load_bcd),
        .load_dp     (load_dp),
        .lz_suppress (lz_suppress),
        .an          (an),
        .seg         (seg),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            an_k[k]  = an;
            seg_k[k] = seg;
            fd_k[k]  = frame_done;
            lr_k[k]  = load_ready;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; load_valid = 1'b0; load_bcd = 16'h0;
        load_dp = 4'h0; lz_suppress = 1'b0;
        step(2);
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || load_ready !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%h seg=%h lr=%b fd=%b expected F FF 0 0",
                     an, seg, load_ready, frame_done);
        end
        rst_n = 1'b1; enable = 1'b1;
        step(5);
        checks++;
        if (an !== 4'hE || seg !== 8'hC0) begin
            errors++;
            $display("FAIL reset_show0: an=%h seg=%h expected E C0", an, seg);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || frame_done !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: an=%h seg=%h fd=%b lr=%b expected F FF 0 0",
                     an, seg, frame_done, load_ready);
        end
        step(2);
        rst_n = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            step(1);
            checks++;
            if (an !== 4'hF || seg !== 8'hFF) begin
                errors++;
                $display("FAIL reset_release_dark%0d: an=%h seg=%h expected F FF", j, an, seg);
            end
        end
        step(1);
        checks++;
        if (an !== 4'hE || seg !== 8'hC0) begin
            errors++;
            $display("FAIL reset_release_digit0: an=%h seg=%h expected E C0", an, seg);
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] exp_seg [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};
        bit ok;
        int fd_cnt;
        int lr_cnt;
        int last;
        load_bcd = 16'h1234; load_dp = 4'b0100; load_valid = 1'b1;
        wait_fd(ok);
        checks++;
        if (!ok || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL scan_sync: fd_seen=%b lr=%b expected 1 1", ok, load_ready);
        end
        capture();
        for (int d = 0; d < 4; d++) begin
            last = (d == 3) ? 32 : 9 + 8 * d;
            checks++;
            if (an_k[4+8*d] !== exp_an[d] || seg_k[4+8*d] !== exp_seg[d]) begin
                errors++;
                $display("FAIL scan_first_d%0d: an=%h seg=%h expected %h %h",
                         d, an_k[4+8*d], seg_k[4+8*d], exp_an[d], exp_seg[d]);
            end
            checks++;
            if (an_k[last] !== exp_an[d] || seg_k[last] !== exp_seg[d]) begin
                errors++;
                $display("FAIL scan_last_d%0d: an=%h seg=%h expected %h %h",
                         d, an_k[last], seg_k[last], exp_an[d], exp_seg[d]);
            end
            checks++;
            if (an_k[2+8*d] !== 4'hF || seg_k[2+8*d] !== 8'hFF ||
                an_k[3+8*d] !== 4'hF || seg_k[3+8*d] !== 8'hFF) begin
                errors++;
                $display("FAIL scan_dark_d%0d: an=%h/%h seg=%h/%h expected F FF",
                         d, an_k[2+8*d], an_k[3+8*d], seg_k[2+8*d], seg_k[3+8*d]);
            end
        end
        fd_cnt = 0; lr_cnt = 0;
        for (int k = 1; k <= 31; k++) begin
            fd_cnt += int'(fd_k[k]);
            lr_cnt += int'(lr_k[k]);
        end
        checks++;
        if (fd_cnt != 0 || lr_cnt != 0 || fd_k[32] !== 1'b1 || lr_k[32] !== 1'b1) begin
            errors++;
            $display("FAIL scan_frame_done: early_fd=%0d early_lr=%0d fd32=%b lr32=%b expected 0 0 1 1",
                     fd_cnt, lr_cnt, fd_k[32], lr_k[32]);
        end
    endtask

    task automatic test_handshake();
        logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] exp_seg [4] = '{8'h80, 8'hF8, 8'h82, 8'h92};
        int bad;
        bit seen;
        load_valid = 1'b0;
        step(12);
        load_valid = 1'b1; load_bcd = 16'h9999; load_dp = 4'h0;
        step(4);
        load_bcd = 16'h5678;
        bad = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            if (load_ready !== 1'b0 || seg[6:0] === 7'h10) bad++;
        end
        checks++;
        if (bad != 0 || !seen || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL hs_ready: bad_cycles=%0d fd_seen=%b lr=%b expected 0 1 1",
                     bad, seen, load_ready);
        end
        capture();
        checks++;
        if (an_k[1] !== 4'h7 || seg_k[1] !== 8'hF9) begin
            errors++;
            $display("FAIL hs_old_tail: an=%h seg=%h expected 7 F9", an_k[1], seg_k[1]);
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an_k[4+8*d] !== exp_an[d] || seg_k[4+8*d] !== exp_seg[d]) begin
                errors++;
                $display("FAIL hs_new_d%0d: an=%h seg=%h expected %h %h",
                         d, an_k[4+8*d], seg_k[4+8*d], exp_an[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] exp_a [4] = '{8'hC0, 8'hF8, 8'hFF, 8'hFF};
        logic [7:0] exp_b [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        logic [3:0] exp_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        load_bcd = 16'h0070; load_dp = 4'h0; lz_suppress = 1'b1;
        capture();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an_k[4+8*d] !== exp_an[d] || seg_k[4+8*d] !== exp_a[d]) begin
                errors++;
                $display("FAIL lz_0070_d%0d: an=%h seg=%h expected %h %h",
                         d, an_k[4+8*d], seg_k[4+8*d], exp_an[d], exp_a[d]);
            end
        end
        load_bcd = 16'h0000;
        capture();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an_k[4+8*d] !== exp_an[d] || seg_k[4+8*d] !== exp_b[d]) begin
                errors++;
                $display("FAIL lz_0000_d%0d: an=%h seg=%h expected %h %h",
                         d, an_k[4+8*d], seg_k[4+8*d], exp_an[d], exp_b[d]);
            end
        end
    endtask

    task automatic test_invalid_code();
        logic [7:0] exp_seg [4] = '{8'hC0, 8'hFF, 8'h90, 8'hFF};
        logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        load_bcd = 16'hA9F0; lz_suppress = 1'b0;
        capture();
        load_valid = 1'b0;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (an_k[4+8*d] !== exp_an[d] || seg_k[4+8*d] !== exp_seg[d]) begin
                errors++;
                $display("FAIL invalid_d%0d: an=%h seg=%h expected %h %h",
                         d, an_k[4+8*d], seg_k[4+8*d], exp_an[d], exp_seg[d]);
            end
        end
    endtask

    task automatic test_enable_toggle();
        int bad;
        bit ok;
        load_bcd = 16'h1234; load_dp = 4'b0100; load_valid = 1'b1;
        step(1);
        load_valid = 1'b0;
        step(21);
        checks++;
        if (an !== 4'hB || seg !== 8'h24) begin
            errors++;
            $display("FAIL en_pre_digit2: an=%h seg=%h expected B 24", an, seg);
        end
        enable = 1'b0; load_valid = 1'b1; load_bcd = 16'h5555; load_dp = 4'hF;
        bad = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || load_ready !== 1'b0) bad++;
            if (i >= 1 && (an !== 4'hF || seg !== 8'hFF)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL en_off_dark: bad_cycles=%0d expected 0", bad);
        end
        enable = 1'b1; load_valid = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            step(1);
            checks++;
            if (an !== 4'hF || seg !== 8'hFF) begin
                errors++;
                $display("FAIL en_restart_dark%0d: an=%h seg=%h expected F FF", j, an, seg);
            end
        end
        step(1);
        checks++;
        if (an !== 4'hE || seg !== 8'h99) begin
            errors++;
            $display("FAIL en_restart_digit0: an=%h seg=%h expected E 99", an, seg);
        end
        wait_fd(ok);
        checks++;
        if (!ok || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL en_next_frame: fd_seen=%b lr=%b expected 1 1", ok, load_ready);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_handshake();
        test_leading_zero();
        test_invalid_code();
        test_enable_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
